// File: rtl/riscv_pkg.sv
// Shared register-file geometry and the load-writeback record carried through
// the writeback buffer.
package riscv_pkg;
  localparam int WIDTH  = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [WIDTH-1:0]  data;
  } lsu_wb_t;
endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of load writeback records; head is visible
// combinationally, pointers wrap modulo DEPTH.
module wb_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  lsu_wb_t                  wrData,
  output lsu_wb_t                  head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  lsu_wb_t         mem [DEPTH];
  logic [PW-1:0]   wrPtr;
  logic [PW-1:0]   rdPtr;
  logic            doPush;
  logic            doPop;

  assign full   = (count == (PW+1)'(DEPTH));
  assign empty  = (count == '0);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign head   = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= wrData;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and buffered load results onto the register
// file write port, with load anti-starvation and an outstanding-load scoreboard.
module wb_arbiter
  import riscv_pkg::*;
#(
  parameter int WIDTH      = riscv_pkg::WIDTH,
  parameter int ADDR_W     = riscv_pkg::ADDR_W,
  parameter int NREG       = riscv_pkg::NREG,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [WIDTH-1:0]  alu_data,
  output logic              alu_stall,
  input  logic              lsu_issue,
  input  logic [ADDR_W-1:0] lsu_issue_rd,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [ADDR_W-1:0] lsu_rd,
  input  logic [WIDTH-1:0]  lsu_data,
  output logic              reg_write,
  output logic [ADDR_W-1:0] AddrD,
  output logic [WIDTH-1:0]  DataD,
  output logic [NREG-1:0]   busy
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  logic [CW-1:0]                  starveCnt;
  logic [CW-1:0]                  starveNext;
  logic [NREG-1:0]                busyNext;
  logic                           fifoFull;
  logic                           fifoEmpty;
  logic [$clog2(FIFO_DEPTH):0]    fifoCount;
  lsu_wb_t                        fifoIn;
  lsu_wb_t                        fifoHead;
  logic                           aluCand;
  logic                           selAlu;
  logic                           selFifo;
  logic                           lsuPush;

  assign alu_stall = (starveCnt == STARVE_LIM);
  assign lsu_ready = !fifoFull;
  assign aluCand   = alu_valid && (alu_rd != '0);
  // x0 load results complete the handshake but never reach the buffer
  assign lsuPush   = lsu_valid && lsu_ready && (lsu_rd != '0);
  assign fifoIn    = '{rd: lsu_rd, data: lsu_data};
  assign selFifo   = !fifoEmpty && (alu_stall || !aluCand);
  assign selAlu    = aluCand && !alu_stall;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) uFifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (lsuPush),
    .pop    (selFifo),
    .wrData (fifoIn),
    .head   (fifoHead),
    .full   (fifoFull),
    .empty  (fifoEmpty),
    .count  (fifoCount)
  );

  always_comb begin
    starveNext = starveCnt;
    if (fifoCount == '0 || selFifo) starveNext = '0;
    else if (starveCnt != STARVE_LIM) starveNext = starveCnt + 1'b1;
  end

  // Clear before set so an issue to the register being written back wins
  always_comb begin
    busyNext = busy;
    if (selFifo) busyNext[fifoHead.rd] = 1'b0;
    if (lsu_issue && lsu_issue_rd != '0) busyNext[lsu_issue_rd] = 1'b1;
    busyNext[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write <= 1'b0;
      AddrD     <= '0;
      DataD     <= '0;
      busy      <= '0;
      starveCnt <= '0;
    end else begin
      reg_write <= selAlu || selFifo;
      if (selAlu) begin
        AddrD <= alu_rd;
        DataD <= alu_data;
      end else if (selFifo) begin
        AddrD <= fifoHead.rd;
        DataD <= fifoHead.data;
      end
      busy      <= busyNext;
      starveCnt <= starveNext;
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: expected writes are queued as stimulus is
// driven and popped whenever the register file write port fires.
module tb_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        alu_stall;
  logic        lsu_issue = 1'b0;
  logic [4:0]  lsu_issue_rd = '0;
  logic        lsu_valid = 1'b0;
  logic        lsu_ready;
  logic [4:0]  lsu_rd = '0;
  logic [31:0] lsu_data = '0;
  logic        reg_write;
  logic [4:0]  AddrD;
  logic [31:0] DataD;
  logic [31:0] busy;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t expQ[$];
  int  nTests = 0;
  int  nFail  = 0;

  wb_arbiter #(.FIFO_DEPTH(2), .STARVE_MAX(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .alu_stall    (alu_stall),
    .lsu_issue    (lsu_issue),
    .lsu_issue_rd (lsu_issue_rd),
    .lsu_valid    (lsu_valid),
    .lsu_ready    (lsu_ready),
    .lsu_rd       (lsu_rd),
    .lsu_data     (lsu_data),
    .reg_write    (reg_write),
    .AddrD        (AddrD),
    .DataD        (DataD),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic pushExp(input logic [4:0] rd, input logic [31:0] data);
    wr_t w;
    w.rd = rd;
    w.data = data;
    expQ.push_back(w);
  endtask

  // Every write-port pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n && reg_write === 1'b1) begin
      checkVal("wrQueued", 64'(expQ.size() > 0), 64'd1);
      if (expQ.size() > 0) begin
        wr_t w;
        w = expQ.pop_front();
        checkVal("wrAddr", 64'(AddrD), 64'(w.rd));
        checkVal("wrData", 64'(DataD), 64'(w.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int k;
    int nStall;
    logic expStall;
    logic accepted;

    // reset values
    step(); step();
    checkVal("rstRegWrite", reg_write, 0);
    checkVal("rstAddrD", AddrD, 0);
    checkVal("rstDataD", DataD, 0);
    checkVal("rstBusy", busy, 0);
    rst_n = 1'b1;
    step();
    checkVal("postRstReady", lsu_ready, 1);
    checkVal("postRstStall", alu_stall, 0);
    checkVal("postRstRegWrite", reg_write, 0);

    // ALU only, then x0 drop
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    pushExp(5'd5, 32'hDEADBEEF);
    step();
    checkVal("aluRegWrite", reg_write, 1);
    checkVal("aluAddrD", AddrD, 5);
    alu_rd = 5'd0; alu_data = 32'h0000_0BAD;
    step();
    checkVal("aluX0RegWrite", reg_write, 0);
    checkVal("aluX0HoldAddr", AddrD, 5);
    checkVal("aluX0HoldData", DataD, 32'hDEADBEEF);
    checkVal("aluX0Stall", alu_stall, 0);
    alu_valid = 1'b0;
    step();

    // load path with scoreboard
    lsu_issue = 1'b1; lsu_issue_rd = 5'd7;
    step();
    lsu_issue = 1'b0;
    checkVal("busy7Set", busy[7], 1);
    step(); step();
    checkVal("loadReady", lsu_ready, 1);
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h1234;
    pushExp(5'd7, 32'h1234);
    step();
    lsu_valid = 1'b0;
    checkVal("loadLatN1", reg_write, 0);
    checkVal("busy7StillSet", busy[7], 1);
    step();
    checkVal("loadLatN2", reg_write, 1);
    checkVal("busy7Clear", busy[7], 0);

    // x0 load result is accepted and discarded
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h0BAD;
    step();
    lsu_valid = 1'b0;
    step(); step();
    checkVal("loadX0Dropped", reg_write, 0);

    // starvation: ALU always valid while rd=9 waits
    lsu_issue = 1'b1; lsu_issue_rd = 5'd9;
    step();
    lsu_issue = 1'b0;
    idx = 0;
    for (int c = 0; c <= 6; c++) begin
      expStall = (c == 5);
      checkVal("starveStall", alu_stall, expStall);
      lsu_valid = (c == 0); lsu_rd = 5'd9; lsu_data = 32'h9999_0009;
      alu_valid = 1'b1; alu_rd = 5'(10 + idx); alu_data = 32'hA000_0000 + 32'(idx);
      if (expStall) pushExp(5'd9, 32'h9999_0009);
      else begin
        pushExp(alu_rd, alu_data);
        idx++;
      end
      step();
    end
    alu_valid = 1'b0; lsu_valid = 1'b0;
    checkVal("starveCleared", alu_stall, 0);
    checkVal("busy9Clear", busy[9], 0);
    step(); step();

    // backpressure: three load results against a continuously valid ALU
    idx = 0; k = 0; nStall = 0;
    for (int c = 0; c <= 16; c++) begin
      expStall = (c == 5) || (c == 10) || (c == 15);
      checkVal("bpStall", alu_stall, expStall);
      accepted = 1'b0;
      if (k < 3) begin
        checkVal("bpReady", lsu_ready, (c < 2) || (c == 6));
        lsu_valid = 1'b1; lsu_rd = 5'(11 + k); lsu_data = 32'hC000_0000 + 32'(k);
        accepted = lsu_ready;
      end else lsu_valid = 1'b0;
      alu_valid = 1'b1; alu_rd = 5'(1 + idx); alu_data = 32'hB000_0000 + 32'(idx);
      if (expStall) begin
        pushExp(5'(11 + nStall), 32'hC000_0000 + 32'(nStall));
        nStall++;
      end else begin
        pushExp(alu_rd, alu_data);
        idx++;
      end
      step();
      if (accepted) k++;
    end
    alu_valid = 1'b0; lsu_valid = 1'b0;
    checkVal("bpAllAccepted", k, 3);
    step(); step();

    // scoreboard collision: re-issue to the register being written back
    lsu_issue = 1'b1; lsu_issue_rd = 5'd3;
    step();
    lsu_issue = 1'b0;
    step();
    lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h3333;
    pushExp(5'd3, 32'h3333);
    step();
    lsu_valid = 1'b0;
    lsu_issue = 1'b1; lsu_issue_rd = 5'd3;
    step();
    lsu_issue = 1'b0;
    checkVal("collideBusy3", busy[3], 1);
    lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h3334;
    pushExp(5'd3, 32'h3334);
    step();
    lsu_valid = 1'b0;
    step();
    checkVal("collideBusy3Clear", busy[3], 0);
    step();

    // reset mid-stream with two buffered loads
    lsu_issue = 1'b1; lsu_issue_rd = 5'd2;
    step();
    lsu_issue_rd = 5'd5;
    step();
    lsu_issue = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hE1;
    pushExp(5'd1, 32'hE1);
    lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h22;
    step();
    alu_data = 32'hE2;
    pushExp(5'd1, 32'hE2);
    lsu_rd = 5'd5; lsu_data = 32'h55;
    step();
    lsu_valid = 1'b0;
    checkVal("midBusy", busy, 32'h0000_0024);
    checkVal("midFull", lsu_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    checkVal("midRstRegWrite", reg_write, 0);
    checkVal("midRstAddrD", AddrD, 0);
    checkVal("midRstDataD", DataD, 0);
    checkVal("midRstBusy", busy, 0);
    checkVal("midRstStall", alu_stall, 0);
    alu_valid = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    checkVal("relReady", lsu_ready, 1);
    checkVal("relBusy", busy, 0);
    checkVal("relRegWrite", reg_write, 0);
    step(); step(); step();
    checkVal("queueDrained", expQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
